float2int32_seq: RTL and testbench
==================================

Name: float2int32_seq

Overview:
Multi-cycle converter from IEEE-754 single precision (1 sign, 8 exponent, 23 mantissa bits) to a 32-bit two's-complement integer. It is the inverse of the int-to-float path in the PE float datapath. An iterative barrel shifter moves at most STEP bits per cycle, which keeps area small. Valid/ready handshakes on both sides let it sit between the PE result register and the integer writeback stage.

Parameters:
STEP, 4, maximum shift distance per SHIFT cycle (1..8)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  in_data is valid
in_ready  out  1  converter can accept a new operand
in_data  in  32  float operand {sign, exp[7:0], mant[22:0]}
out_valid  out  1  result held and valid
out_ready  in  1  downstream accepts the result
out_data  out  32  signed integer result
out_ovf  out  1  result was saturated (overflow or infinity)
out_nan  out  1  operand was NaN

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0, out_nan=0, shift register and count cleared.
- Reset mid-operation aborts the conversion immediately. No result is emitted for that operand.
- FSM states: IDLE, SHIFT, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- Accept occurs when in_valid & in_ready. in_data is captured on that edge and later changes on in_data are ignored.
- Classification on accept, with e = exp - 127:
  - exp=255, mant!=0 (NaN): result 0, nan=1, go DONE.
  - exp=255, mant=0 (infinity): saturate, ovf=1, go DONE.
  - exp<127 (zero, denormal, or |x|<1): result 0, go DONE.
  - e>=31: saturate, ovf=1, go DONE. Exception: in_data=0xCF000000 gives 0x80000000 with ovf=0.
  - e=23: result = sign ? -{9'b1,mant} : {9'b1,mant}, go DONE.
  - e<23: load {8'b0,1,mant}, right-shift count n=23-e (1..23), go SHIFT.
  - 23<e<31: load the same value, left-shift count n=e-23 (1..7), go SHIFT.
- Saturation value: 0x7FFFFFFF if sign=0, 0x80000000 if sign=1.
- SHIFT state:
  - Each cycle shifts by min(n_rem, STEP) and decrements n_rem by that amount.
  - On the cycle where n_rem <= STEP, the final shift and sign negation (two's complement) are written to out_data, and the FSM goes to DONE.
- Rounding is truncation toward zero: discarded bits are dropped before negation.
- Latency, in rising edges from the accept edge to out_valid=1:
  - 1 for special cases and e=23.
  - 1 + ceil(n/STEP) for shifted cases.
- DONE state:
  - out_data, out_ovf and out_nan are held stable while out_valid=1 and out_ready=0.
  - When out_ready=1: go IDLE next edge with out_valid=0. in_ready rises in the same cycle. Outputs keep their last value; they are only meaningful while out_valid=1.
  - No accept occurs while in DONE (no overlap). Minimum issue interval is latency+1 cycles.
- out_ovf and out_nan are mutually exclusive and are cleared on every accept.
- Sign bit on zero results is ignored: -0.0 and -0.5 produce 0.

Test Plan:
- Reset mid-SHIFT (assert rst during a 1.0 conversion) -> outputs are reset-state values immediately; no out_valid follows. A following 0x3F800000 converts normally to 1.
- 0x3F800000 (1.0), STEP=4 -> out_data=0x00000001, out_valid 7 edges after accept, ovf=0, nan=0.
- 0xC2F6E979 (-123.456) -> out_data=0xFFFFFF85, latency 6. 0x4B000001 -> 0x00800001, latency 1. 0x4E800000 (2^30) -> 0x40000000, latency 3.
- Saturation and specials:
  - 0x4F000000 -> 0x7FFFFFFF, ovf=1.
  - 0xCF000000 -> 0x80000000, ovf=0.
  - 0xFF800000 (-inf) -> 0x80000000, ovf=1.
  - 0x7FC00000 (NaN) -> 0, nan=1.
  - 0x3EFFFFFF and 0x80000001 -> 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data stable and in_ready=0 throughout. When out_ready rises, in_ready=1 on the next cycle.
- Randomised stream of 1000 operands with random in_valid/out_ready gaps -> every result matches a truncating reference model. No operand is lost or duplicated.

Source files
------------

// File: rtl/float2int32_seq.sv
// float2int32_seq: iterative float32 to int32 converter with valid/ready handshakes
module float2int32_seq #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_ovf,
    output logic        out_nan
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [4:0] S = 5'(STEP);
    state_t      st, nx;
    logic [31:0] sr, base, sat, sp_res, sh;
    logic [4:0]  cnt, amt, n;
    logic [7:0]  ex;
    logic [22:0] mt;
    logic        left, sg, acc, spec, last, sp_ovf, sp_nan;
    assign ex        = in_data[30:23];
    assign mt        = in_data[22:0];
    assign in_ready  = st == IDLE;
    assign out_valid = st == DONE;
    assign acc       = in_valid && in_ready;
    assign base      = {8'b0, 1'b1, mt};
    assign sat       = in_data[31] ? 32'h8000_0000 : 32'h7fff_ffff;
    assign spec      = ex == 8'd255 || ex < 8'd127 || ex >= 8'd158 || ex == 8'd150;
    assign sp_nan    = ex == 8'd255 && mt != 23'd0;
    assign sp_ovf    = (ex == 8'd255 && mt == 23'd0) || (ex >= 8'd158 && ex != 8'd255 && in_data != 32'hcf00_0000);
    assign sp_res    = ex == 8'd255 ? (mt != 23'd0 ? 32'd0 : sat) :
                       ex < 8'd127  ? 32'd0 :
                       ex >= 8'd158 ? sat :
                       (in_data[31] ? -base : base);
    assign n         = ex < 8'd150 ? 5'd22 - ex[4:0] : ex[4:0] - 5'd22;
    assign last      = cnt <= S;
    assign amt       = last ? cnt : S;
    assign sh        = left ? sr << amt : sr >> amt;
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= nx;
    end
    // next-state selection
    always_comb begin
        nx = st;
        case (st)
            IDLE:    nx = acc ? (spec ? DONE : SHIFT) : IDLE;
            SHIFT:   nx = last ? DONE : SHIFT;
            DONE:    nx = out_ready ? IDLE : DONE;
            default: nx = IDLE;
        endcase
    end
    // operand capture, iterative shift and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr       <= '0;
            cnt      <= '0;
            left     <= 1'b0;
            sg       <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
            out_nan  <= 1'b0;
        end else if (acc) begin
            sg      <= in_data[31];
            sr      <= base;
            cnt     <= n;
            left    <= ex > 8'd150;
            out_ovf <= sp_ovf;
            out_nan <= sp_nan;
            if (spec) out_data <= sp_res;
        end else if (st == SHIFT) begin
            sr  <= sh;
            cnt <= cnt - amt;
            if (last) out_data <= sg ? -sh : sh;
        end
    end
endmodule

// File: tb/tb_float2int32_seq.sv
// tb_float2int32_seq: directed and streamed checks of the float to int converter
module tb_float2int32_seq;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_ovf, out_nan;
    logic [31:0] in_data = '0, out_data;
    int          checks = 0, failures = 0;

    float2int32_seq #(.STEP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_nan(out_nan)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] model(input logic [31:0] f);
        logic [63:0] mag;
        logic [31:0] sat;
        int e;
        sat = f[31] ? 32'h8000_0000 : 32'h7fff_ffff;
        e = int'(f[30:23]) - 127;
        if (f[30:23] == 8'hff) return f[22:0] != 0 ? {2'b10, 32'h0} : {2'b01, sat};
        if (e < 0) return 34'h0;
        if (e > 40) return {2'b01, sat};
        mag = {40'h0, 1'b1, f[22:0]};
        mag = e >= 23 ? mag << (e - 23) : mag >> (23 - e);
        if (mag > 64'h7fff_ffff)
            return (f[31] && mag == 64'h8000_0000) ? {2'b00, 32'h8000_0000} : {2'b01, sat};
        return {2'b00, f[31] ? -mag[31:0] : mag[31:0]};
    endfunction

    task automatic convert(input logic [31:0] d, output logic [33:0] r, output int lat);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin @(negedge clk); w++; end
        in_valid = 1'b1; in_data = d; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = ~d;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        r = {out_nan, out_ovf, out_data};
        checks++;
        if (!out_valid) begin failures++; $display("FAIL timeout op=%h out_valid=%b required 1", d, out_valid); end
    endtask

    task automatic release_out;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({in_ready, out_valid, out_data, out_ovf, out_nan} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset rdy=%b vld=%b data=%h ovf=%b nan=%b required 1 0 0 0 0", in_ready, out_valid, out_data, out_ovf, out_nan);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [31:0] d[4] = '{32'h3F80_0000, 32'hC2F6_E979, 32'h4B00_0001, 32'h4E80_0000};
        logic [31:0] x[4] = '{32'h0000_0001, 32'hFFFF_FF85, 32'h0080_0001, 32'h4000_0000};
        int          l[4] = '{7, 6, 1, 3};
        logic [33:0] r;
        int lat;
        for (int i = 0; i < 4; i++) begin
            convert(d[i], r, lat);
            checks++;
            if (r !== {2'b00, x[i]} || lat !== l[i]) begin
                failures++;
                $display("FAIL basic op=%h got %h lat %0d required %h lat %0d", d[i], r, lat, {2'b00, x[i]}, l[i]);
            end
            release_out();
        end
    endtask

    task automatic test_special;
        logic [31:0] d[6] = '{32'h4F00_0000, 32'hCF00_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h3EFF_FFFF, 32'h8000_0001};
        logic [33:0] x[6] = '{{2'b01, 32'h7FFF_FFFF}, {2'b00, 32'h8000_0000}, {2'b01, 32'h8000_0000},
                              {2'b10, 32'h0}, {2'b00, 32'h0}, {2'b00, 32'h0}};
        logic [33:0] r;
        int lat;
        for (int i = 0; i < 6; i++) begin
            convert(d[i], r, lat);
            checks++;
            if (r !== x[i] || lat !== 1) begin
                failures++;
                $display("FAIL special op=%h got {nan,ovf,data}=%h lat %0d required %h lat 1", d[i], r, lat, x[i]);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure;
        logic [33:0] r;
        int lat;
        convert(32'hC2F6_E979, r, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_data !== 32'hFFFF_FF85 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL hold cyc=%0d data=%h rdy=%b vld=%b required ffffff85 0 1", i, out_data, in_ready, out_valid);
            end
        end
        release_out();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL release rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid;
        logic [33:0] r;
        int lat, seen = 0;
        @(negedge clk); in_valid = 1'b1; in_data = 32'h3F80_0000;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, out_ovf, out_nan} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midreset rdy=%b vld=%b data=%h ovf=%b nan=%b required 1 0 0 0 0", in_ready, out_valid, out_data, out_ovf, out_nan);
        end
        @(negedge clk); rst = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL aborted valid cycles=%0d required 0", seen); end
        convert(32'h3F80_0000, r, lat);
        checks++;
        if (r !== 34'h1 || lat !== 7) begin
            failures++;
            $display("FAIL after reset got %h lat %0d required 000000001 lat 7", r, lat);
        end
        release_out();
    endtask

    task automatic test_random;
        logic [31:0] ops[1000];
        logic [33:0] expq[$];
        logic [33:0] e;
        logic [7:0]  ex;
        int sent = 0, recv = 0, cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            ex = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(120, 160));
            ops[i] = {1'($urandom), ex, 23'($urandom)};
            if (i % 97 == 0) ops[i] = 32'hCF00_0000;
        end
        while (recv < 1000 && cyc < 50000) begin
            @(negedge clk); cyc++;
            in_valid  = sent < 1000 && $urandom_range(0, 3) != 0;
            in_data   = sent < 1000 ? ops[sent] : 32'h0;
            out_ready = $urandom_range(0, 2) != 0;
            #1;
            if (in_valid && in_ready) begin expq.push_back(model(in_data)); sent++; end
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL stream extra result %h", out_data);
                end else begin
                    e = expq.pop_front();
                    if ({out_nan, out_ovf, out_data} !== e) begin
                        failures++;
                        $display("FAIL stream n=%0d got %h required %h", recv, {out_nan, out_ovf, out_data}, e);
                    end
                end
                recv++;
            end
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (recv !== 1000 || expq.size() !== 0) begin
            failures++;
            $display("FAIL stream count recv=%0d pending=%0d required 1000 0", recv, expq.size());
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_special();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
